// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam int unsigned DEF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu.sv
// Combinational signed ALU: add/sub wrap modulo 2^W, bitwise and/or.
module alu
    import alu_sched_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic signed [W-1:0] A,
    input  logic signed [W-1:0] B,
    input  logic        [1:0]   ctrl,
    output logic signed [W-1:0] out
);

    always_comb begin
        out = '0;
        case (ctrl)
            OP_ADD:  out = A + B;
            OP_SUB:  out = A - B;
            OP_AND:  out = A & B;
            OP_OR:   out = A | B;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request scanning from ptr upward, modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU among NREQ requesters with a valid/ready result channel.
// Optional op_count output enabled by defining ALU_SCHED_OPCNT_EN.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = DEF_W,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_out,
`ifdef ALU_SCHED_OPCNT_EN
    output logic [15:0]       op_count,
`endif
    output logic              busy
);

    state_t state, state_nxt;

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;

    logic [W-1:0]    op_a, op_b;
    logic [1:0]      op_ctrl;
    logic [IDW-1:0]  op_id;
    logic [W-1:0]    alu_out;

    logic            load, capture, rsp_done;

    logic [W-1:0]    a_arr    [NREQ];
    logic [W-1:0]    b_arr    [NREQ];
    logic [1:0]      ctrl_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]    = req_a[i*W +: W];
        assign b_arr[i]    = req_b[i*W +: W];
        assign ctrl_arr[i] = req_ctrl[i*2 +: 2];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    alu #(
        .W (W)
    ) u_alu (
        .A    (op_a),
        .B    (op_b),
        .ctrl (op_ctrl),
        .out  (alu_out)
    );

    // Grant is offered only while idle and out of reset.
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    load      = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, pointer rotation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_ctrl   <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
        end else begin
            if (load) begin
                op_a    <= a_arr[gnt_idx];
                op_b    <= b_arr[gnt_idx];
                op_ctrl <= ctrl_arr[gnt_idx];
                op_id   <= gnt_idx;
                rr_ptr  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (capture) begin
                rsp_out   <= alu_out;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SCHED_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_done && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: directed vectors, expectations queued at grant, checked at response.
module tb_alu_rr_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*2-1:0] req_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_out;
    logic              busy;
`ifdef ALU_SCHED_OPCNT_EN
    logic [15:0]       op_count;
`endif

    alu_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
`ifdef ALU_SCHED_OPCNT_EN
        .op_count  (op_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hs_count  = 0;
    int rsp_count = 0;

    logic [3:0] cur_exp [NREQ];
    int sb_id  [$];
    int sb_out [$];
    int exp_order [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Grant watcher: on each accepted request, queue the hand-computed response.
    always @(negedge clk) begin
        if (rst_n && |(req_ready & req_valid)) begin
            int g;
            g = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            chk("ready_onehot", int'($countones(req_ready) > 1), 0);
            if (exp_order.size() > 0) chk("grant_order", g, exp_order.pop_front());
            sb_id.push_back(g);
            sb_out.push_back(int'(cur_exp[g]));
            hs_count++;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_id.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", int'(rsp_id), sb_id.pop_front());
                chk("rsp_out", int'(rsp_out), sb_out.pop_front());
            end
            rsp_count++;
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] c, input logic [3:0] e);
        req_a[i*4 +: 4]    = a;
        req_b[i*4 +: 4]    = b;
        req_ctrl[i*2 +: 2] = c;
        cur_exp[i]         = e;
        req_valid[i]       = 1'b1;
    endtask

    // Raise one request, wait for its grant, drop valid after the accepting edge.
    task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] c, input logic [3:0] e);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(i, a, b, c, e);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) chk("grant_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!busy && sb_id.size() == 0) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_grants(input int n);
        int base;
        base = hs_count;
        for (int k = 0; k < 200 && hs_count < base + n; k++) @(posedge clk);
        if (hs_count < base + n) chk("grants_timeout", hs_count - base, n);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) cur_exp[i] = '0;

        // Reset values, with a request pending during reset.
        set_req(0, 4'd3, 4'd2, 2'b00, 4'b0101);
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_out", int'(rsp_out), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);

        // Single request: ready same cycle, response after two edges.
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("single_ready", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("exec_rsp_valid", int'(rsp_valid), 0);
        chk("exec_busy", int'(busy), 1);
        @(negedge clk);
        chk("resp_rsp_valid", int'(rsp_valid), 1);
        wait_idle();

        // Wrap arithmetic and logic ops.
        issue(1, 4'b1000, 4'b0001, 2'b01, 4'b0111);
        wait_idle();
        issue(1, 4'b0111, 4'b0001, 2'b00, 4'b1000);
        wait_idle();
        issue(2, 4'b0110, 4'b0011, 2'b10, 4'b0010);
        wait_idle();
        issue(3, 4'b0101, 4'b1010, 2'b11, 4'b1111);
        wait_idle();
        chk("rsp_keeps_value", int'(rsp_out), 15);

        // Fairness from a fresh reset with all requesters valid.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 4'b0001, 4'b0001, 2'b00, 4'b0010);
        set_req(1, 4'b0101, 4'b0111, 2'b01, 4'b1110);
        set_req(2, 4'b1100, 4'b1010, 2'b10, 4'b1000);
        set_req(3, 4'b0001, 4'b0100, 2'b11, 4'b0101);
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
        exp_order.push_back(3); exp_order.push_back(0); exp_order.push_back(1);
        wait_grants(6);
        req_valid = '0;
        wait_idle();
        chk("fair_order_drained", exp_order.size(), 0);

        // Backpressure: result holds while rsp_ready is low, other requester waits.
        rsp_ready = 1'b0;
        issue(2, 4'b0001, 4'b0001, 2'b00, 4'b0010);
        set_req(0, 4'b0010, 4'b0011, 2'b00, 4'b0101);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_out", int'(rsp_out), 2);
            chk("bp_rsp_id", int'(rsp_id), 2);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resume_ready", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();

        // Reset during EXEC discards the transaction and rewinds the pointer.
        issue(1, 4'b0011, 4'b0011, 2'b00, 4'b0110);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        sb_id.delete();
        sb_out.delete();
        exp_order.delete();
        rsp_count = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1, 4'b0010, 4'b0001, 2'b01, 4'b0001);
        set_req(3, 4'b0100, 4'b0100, 2'b10, 4'b0100);
        exp_order.push_back(1);
        exp_order.push_back(3);
        wait_grants(1);
        req_valid[1] = 1'b0;
        wait_grants(1);
        req_valid[3] = 1'b0;
        wait_idle();
        chk("midrst_order_drained", exp_order.size(), 0);

`ifdef ALU_SCHED_OPCNT_EN
        issue(0, 4'b0001, 4'b0010, 2'b00, 4'b0011);
        wait_idle();
        issue(1, 4'b0001, 4'b0010, 2'b01, 4'b1111);
        wait_idle();
        issue(2, 4'b0011, 4'b0101, 2'b10, 4'b0001);
        wait_idle();
        issue(3, 4'b0011, 4'b0101, 2'b11, 4'b0111);
        wait_idle();
        chk("opcnt_six", int'(op_count), 6);
        chk("opcnt_bench_six", rsp_count, 6);
        @(posedge clk); #1;
        force dut.op_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.op_count;
        issue(0, 4'b0001, 4'b0001, 2'b00, 4'b0010);
        wait_idle();
        chk("opcnt_saturate", int'(op_count), 65535);
`endif

        chk("sb_empty", sb_id.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one instance of the existing 4-bit signed `alu` (ports A, B, ctrl, out) among NREQ requesters.
- Arbitrates, latches the winner's operands and opcode, drives the ALU, registers the result, and returns it tagged with the requester id through a valid/ready response channel.
- Sits between the operand-producing clients and the single combinational ALU datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand/result width; must match the alu width.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*W  operand A, slice i for requester i, signed.
- req_b  in  NREQ*W  operand B, slice i, signed.
- req_ctrl  in  NREQ*2  opcode, slice i: 00 add, 01 sub, 10 and, 11 or.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  id of the requester that owns rsp_out.
- rsp_out  out  W  registered ALU result, signed, wraps modulo 2^W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - Operand registers cleared.
  - rsp_valid=0, rsp_id=0, rsp_out=0, busy=0, req_ready=0.
- FSM IDLE:
  - req_ready[g]=1 combinationally, where g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - No valid requester: stay in IDLE, req_ready=0.
  - Handshake (valid&ready): latch req_a[g], req_b[g], req_ctrl[g] and id g; set rr_ptr=(g+1) mod NREQ; go to EXEC.
- FSM EXEC (1 cycle):
  - Latched operands drive alu A/B/ctrl.
  - At the clock edge, alu out is captured into rsp_out and id into rsp_id; rsp_valid goes to 1; go to RESP.
- FSM RESP:
  - rsp_valid=1; rsp_out and rsp_id stay stable until rsp_ready=1 at a clock edge.
  - On that edge, rsp_valid goes to 0 and the FSM returns to IDLE.
  - req_ready=0 for every requester throughout EXEC and RESP.
- Latency: accept at edge t, rsp_valid high after edge t+1. Minimum initiation interval is 3 cycles (IDLE, EXEC, RESP).
- Requesters must hold valid and operands stable until accepted. Dropping valid before ready is legal; the request is simply not taken.
- Simultaneous requests: rotating priority only. A requester waits at most NREQ-1 grants.
- rr_ptr updates only on a handshake.
- A requester re-asserting valid in the cycle after its response competes normally.
- rsp_out keeps its value after the response handshake; only rsp_valid drops.
- rst_n asserted mid-operation: the transaction is discarded with no response, and all state returns to reset values immediately (async).
- Arithmetic: add/sub wrap modulo 16 (e.g. 7+1 gives -8). No saturation.

Optional Feature:
- Macro ALU_SCHED_OPCNT_EN.
- Defined:
  - Extra output op_count [15:0]: number of completed response handshakes.
  - Saturates at 16'hFFFF; reset to 0.
  - Increments on the edge where rsp_valid&rsp_ready.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_sched_pkg:
  - state enum {IDLE, EXEC, RESP};
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - default width W=4.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any.
- The top instantiates rr_pick and alu.

Test Plan:
- Single request: req0 valid, A=3, B=2, ctrl=00 → req_ready[0] high the same cycle; rsp_valid two edges later with rsp_out=0101, rsp_id=0.
- Wrap/sub: req1 A=-8, B=1, ctrl=01 → rsp_out=0111 (+7), rsp_id=1; and req1 A=7, B=1, ctrl=00 → rsp_out=1000.
- Fairness: all 4 valid continuously after reset → grant order 0,1,2,3,0,1; each requester receives exactly one response per 4 operations.
- Backpressure: rsp_ready held 0 for 5 cycles → rsp_valid, rsp_out and rsp_id stable; req_ready all 0; busy=1; accept resumes the cycle after rsp_ready=1.
- Reset mid-op: rst_n pulsed low during EXEC → rsp_valid=0, busy=0 immediately; the next request is granted starting from id 0.
- With ALU_SCHED_OPCNT_EN: 6 completed operations → op_count=6; a forced count at 16'hFFFF stays at 16'hFFFF after another operation.
